// File: rtl/dcache_direct_wb.sv
// ---------------------------------------------------------------------------
// dcache_direct_wb
//
// Direct-mapped, write-back, write-allocate data cache placed between the
// pipeline data port and a block-wide main-memory port.
//
// Hits complete in the request cycle without a stall. On a miss the cache
// stalls the pipeline. It writes back the dirty victim line, if there is one,
// and then refills the line. The request is completed in the IDLE cycle that
// follows the refill. A write miss merges its word into the refilled line in
// that cycle.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   proc_ren     read request  (held stable by the pipeline while stalled)
//   proc_wen     write request (held stable while stalled; wins over ren)
//   proc_addr    word address: [1:0] offset, [4:2] index, [29:5] tag
//   proc_wdata   write data
//   proc_stall   1 = request not completed this cycle (combinational)
//   proc_rdata   word selected by proc_addr from the indexed line
//   mem_read     refill request (registered, follows state)
//   mem_write    write-back request (registered, follows state)
//   mem_addr     block address {tag,index}
//   mem_wdata    victim line, word0 on [31:0]
//   mem_ready    one-cycle pulse: current memory transaction finished
//   mem_rdata    refill line, valid while mem_ready=1 during a refill
// ---------------------------------------------------------------------------
module dcache_direct_wb #(
  parameter  int NUM_BLOCKS      = 8,
  parameter  int WORDS_PER_BLOCK = 4,
  parameter  int ADDR_W          = 30,
  localparam int IDX_W           = $clog2(NUM_BLOCKS),
  localparam int OFF_W           = $clog2(WORDS_PER_BLOCK),
  localparam int TAG_W           = ADDR_W - IDX_W - OFF_W,
  localparam int BLK_W           = ADDR_W - OFF_W,
  localparam int LINE_W          = 32 * WORDS_PER_BLOCK
) (
  input  logic              clk,
  input  logic              rst_n,
  // pipeline side
  input  logic              proc_ren,
  input  logic              proc_wen,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic              proc_stall,
  output logic [31:0]       proc_rdata,
  // main-memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [BLK_W-1:0]  mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t state;

  // Line storage. Data is kept as packed words per line so that word0 lands
  // on bits [31:0] when a whole line moves to or from memory.
  logic [NUM_BLOCKS-1:0]                 valid;
  logic [NUM_BLOCKS-1:0]                 dirty;
  logic [TAG_W-1:0]                      tags [NUM_BLOCKS];
  logic [WORDS_PER_BLOCK-1:0][31:0]      data [NUM_BLOCKS];

  // Address fields of the present request.
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [TAG_W-1:0] tag;

  assign off = proc_addr[OFF_W-1:0];
  assign idx = proc_addr[OFF_W +: IDX_W];
  assign tag = proc_addr[ADDR_W-1 -: TAG_W];

  logic req;
  logic hit;

  assign req = proc_ren | proc_wen;
  assign hit = valid[idx] & (tags[idx] == tag);

  // Stall depends only on state, arrays and the present request. There is
  // deliberately no path from mem_ready. The refill lands at the edge, and
  // the following IDLE cycle then sees a hit.
  always_comb begin
    // NOTE: assign a default first so no path through the block leaves the
    // output unassigned; otherwise a latch is inferred.
    proc_stall = 1'b1;
    if (state == S_IDLE) begin
      proc_stall = req & ~hit;
    end
  end

  assign proc_rdata = data[idx][off];

  // Single-block FSM. The memory-side outputs are registered and are loaded
  // on the edge that enters each state, so they are pure functions of state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: state updates use non-blocking assignments so that every
      // right-hand side sees pre-edge values, regardless of statement order.
      state     <= S_IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid     <= '0;
      dirty     <= '0;
      // NOTE: the tag and data arrays are cleared as well. After reset the
      // read port must show zeros, so these arrays stay flops and are not
      // mapped to RAM macros.
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            if (hit) begin
              // When ren and wen are both high, the access is a write.
              if (proc_wen) begin
                data[idx][off] <= proc_wdata;
                dirty[idx]     <= 1'b1;
              end
            end else if (valid[idx] && dirty[idx]) begin
              state     <= S_WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {tags[idx], idx};
              mem_wdata <= data[idx];
            end else begin
              state    <= S_ALLOCATE;
              mem_read <= 1'b1;
              mem_addr <= proc_addr[ADDR_W-1:OFF_W];
            end
          end
        end

        S_WRITEBACK: begin
          // The victim outputs stay frozen until memory accepts them. The
          // hand-over to refill occurs on one edge: write falls, read rises.
          if (mem_ready) begin
            state     <= S_ALLOCATE;
            mem_write <= 1'b0;
            mem_wdata <= '0;
            mem_read  <= 1'b1;
            mem_addr  <= proc_addr[ADDR_W-1:OFF_W];
          end
        end

        S_ALLOCATE: begin
          if (mem_ready) begin
            data[idx]  <= mem_rdata;
            tags[idx]  <= tag;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            state      <= S_IDLE;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
          end
        end

        default: begin
          state     <= S_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// ---------------------------------------------------------------------------
// tb_dcache_direct_wb
//
// Self-checking bench for dcache_direct_wb. The first part is a set of
// directed steps. A run of random accesses follows. Each access is scored
// against a reference that treats the cache as transparent. The value
// expected from any word is the last value written to it, or else the
// contents of the backing memory. A residency table for each index predicts
// hits, dirty victims and the exact number of stall cycles. The bench plays
// the memory. It serves refills from its own backing store and keeps every
// line written back to it.
// ---------------------------------------------------------------------------
module tb_dcache_direct_wb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_ren = 1'b0;
  logic         proc_wen = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready = 1'b0;
  logic [127:0] mem_rdata = '0;

  dcache_direct_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_ren   (proc_ren),
    .proc_wen   (proc_wen),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Backing memory (line per block address) and architectural word values.
  logic [127:0] bmem [logic [27:0]];
  logic [31:0]  arch [logic [29:0]];

  // Which block each index holds, as seen from outside.
  logic         mv [8];
  logic         md [8];
  logic [24:0]  mt [8];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] bmem_line(input logic [27:0] b);
    if (bmem.exists(b)) return bmem[b];
    return {b, 2'd3, 2'b01, b, 2'd2, 2'b01, b, 2'd1, 2'b01, b, 2'd0, 2'b01};
  endfunction

  function automatic logic [31:0] exp_word(input logic [29:0] a);
    logic [127:0] l;
    if (arch.exists(a)) return arch[a];
    l = bmem_line(a[29:2]);
    return l[32*a[1:0] +: 32];
  endfunction

  function automatic logic [127:0] exp_line(input logic [27:0] b);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = exp_word({b, 2'(w)});
    return l;
  endfunction

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // One complete processor access. Memory answers after wb_d extra cycles
  // in write-back and rf_d extra cycles in refill. A delay of 0 means that
  // mem_ready comes in the first cycle of the state.
  task automatic access(input bit wr, input bit both, input logic [29:0] a,
                        input logic [31:0] wd, input int wb_d, input int rf_d);
    int          idx;
    bit          hit, victim_dirty, done, saw_wb, saw_rd;
    int          stalls, wcnt, rcnt, exp_stalls;
    logic [27:0] vblk;
    idx          = int'(a[4:2]);
    hit          = mv[idx] && (mt[idx] == a[29:5]);
    victim_dirty = !hit && mv[idx] && md[idx];
    vblk         = {mt[idx], a[4:2]};
    done = 0; saw_wb = 0; saw_rd = 0; stalls = 0; wcnt = 0; rcnt = 0;

    @(negedge clk);
    proc_ren   = !wr || both;
    proc_wen   = wr;
    proc_addr  = a;
    proc_wdata = wd;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (!proc_stall) begin
        done = 1;
        break;
      end
      stalls++;
      if (mem_write) begin
        if (!saw_wb) begin
          check("wb_addr", mem_addr, vblk);
          check("wb_data", mem_wdata, exp_line(vblk));
          saw_wb = 1;
        end
        if (wcnt == wb_d) begin
          bmem[mem_addr] = mem_wdata;
          mem_ready = 1'b1;
        end
        wcnt++;
      end else if (mem_read) begin
        if (!saw_rd) begin
          check("rf_addr", mem_addr, a[29:2]);
          saw_rd = 1;
        end
        if (rcnt == rf_d) begin
          mem_rdata = bmem_line(mem_addr);
          mem_ready = 1'b1;
        end
        rcnt++;
      end
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = '0;
    end
    if (!done) begin
      check("timeout", 1'b0, 1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "access did not complete");
    end

    exp_stalls = hit ? 0 : 1 + (victim_dirty ? wb_d + 1 : 0) + rf_d + 1;
    check("stall_cycles", stalls, exp_stalls);
    check("saw_writeback", saw_wb, victim_dirty);
    check("saw_refill", saw_rd, !hit);
    check("idle_mem_req", {mem_read, mem_write}, 2'b00);
    if (!wr) check("rdata", proc_rdata, exp_word(a));

    @(posedge clk);
    if (!hit) begin
      mv[idx] = 1'b1;
      mt[idx] = a[29:5];
      md[idx] = 1'b0;
    end
    if (wr) begin
      arch[a] = wd;
      md[idx] = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0; md[i] = 1'b0; mt[i] = '0;
    end
    bmem[28'h4] = {32'hD, 32'hC, 32'hB, 32'hA};

    // Reset and idle outputs.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_stall", proc_stall, 1'b0);
    check("rst_rdata", proc_rdata, 32'h0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_addr, 28'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);

    // mem_ready in IDLE has no effect.
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("idle_ready_ignored", {mem_read, mem_write, proc_stall}, 3'b000);

    // Directed sequence.
    access(0, 0, 30'h10, 32'h0, 0, 0);          // cold miss -> 0xA
    access(0, 0, 30'h13, 32'h0, 0, 0);          // hit -> 0xD
    access(1, 0, 30'h11, 32'h12345678, 0, 0);   // write hit, line dirty
    access(0, 0, 30'h11, 32'h0, 0, 0);          // reads back 0x12345678
    access(0, 0, 30'h30, 32'h0, 5, 2);          // dirty conflict
    access(0, 0, 30'h13, 32'h0, 0, 0);          // the written-back value reloads
    access(1, 0, 30'h45, 32'hCAFEF00D, 0, 1);   // write miss, refill only
    access(0, 0, 30'h45, 32'h0, 0, 0);          // hit, 0xCAFEF00D
    access(0, 0, 30'h25, 32'h0, 0, 0);          // evicts the now-dirty line
    access(1, 1, 30'h25, 32'h0BADF00D, 0, 0);   // ren & wen together is a write
    access(0, 0, 30'h25, 32'h0, 0, 0);

    // Reset in the middle of a refill.
    access(0, 0, 30'h30, 32'h0, 0, 0);
    @(negedge clk);
    proc_ren = 1'b1; proc_wen = 1'b0; proc_addr = 30'h13;
    #1;
    check("pre_rst_stall", proc_stall, 1'b1);
    @(negedge clk);
    #1;
    check("alloc_mem_read", mem_read, 1'b1);
    check("alloc_mem_addr", mem_addr, 28'h4);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_mem_read", mem_read, 1'b0);
    check("mid_rst_mem_write", mem_write, 1'b0);
    check("mid_rst_mem_addr", mem_addr, 28'h0);
    check("mid_rst_stall", proc_stall, 1'b1);
    check("mid_rst_rdata", proc_rdata, 32'h0);
    rst_n = 1'b1;
    proc_ren = 1'b0;
    #1;
    check("post_rst_idle_stall", proc_stall, 1'b0);
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0; md[i] = 1'b0;
    end
    arch.delete();  // dirty data held only in the cache is lost
    access(0, 0, 30'h13, 32'h0, 0, 0);          // misses after reset

    // Random accesses over a few tags so that indices conflict.
    for (int n = 0; n < 300; n++) begin
      logic [29:0] a;
      bit          wr, both;
      a[1:0]  = 2'($urandom_range(0, 3));
      a[4:2]  = 3'($urandom_range(0, 7));
      a[29:5] = ($urandom_range(0, 9) == 0) ? 25'($urandom) : 25'($urandom_range(0, 3));
      wr      = 1'($urandom_range(0, 1));
      both    = wr && ($urandom_range(0, 3) == 0);
      access(wr, both, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk);
    proc_ren = 1'b0;
    proc_wen = 1'b0;
    #1;
    check("final_idle_stall", proc_stall, 1'b0);
    finish_run();
  end

endmodule
